// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared definitions for the PS/2 keyboard controller: prefix bytes, the
// controller response codes that are filtered out, and the sequencer states.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR_LO = 8'h00;
  localparam logic [7:0] PS2_ERR_HI = 8'hFF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_POP    = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_DECODE = 3'd3;
  localparam logic [2:0] ST_EMIT   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_POP    = ST_POP,
    S_SETTLE = ST_SETTLE,
    S_DECODE = ST_DECODE,
    S_EMIT   = ST_EMIT
  } ps2_state_e;

  function automatic logic is_filter_code(input logic [7:0] b);
    return (b == PS2_ACK)    || (b == PS2_BAT_OK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
  endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_scan2ascii.sv
// Combinational set-2 scan code to lowercase ASCII lookup for letters, digits,
// space and enter; every other code maps to 0.
module ps2_scan2ascii (
  input  logic [7:0] i_code,
  output logic [7:0] o_ascii
);

  always_comb begin
    o_ascii = 8'h00;
    case (i_code)
      8'h1C: o_ascii = 8'h61;
      8'h32: o_ascii = 8'h62;
      8'h21: o_ascii = 8'h63;
      8'h23: o_ascii = 8'h64;
      8'h24: o_ascii = 8'h65;
      8'h2B: o_ascii = 8'h66;
      8'h34: o_ascii = 8'h67;
      8'h33: o_ascii = 8'h68;
      8'h43: o_ascii = 8'h69;
      8'h3B: o_ascii = 8'h6A;
      8'h42: o_ascii = 8'h6B;
      8'h4B: o_ascii = 8'h6C;
      8'h3A: o_ascii = 8'h6D;
      8'h31: o_ascii = 8'h6E;
      8'h44: o_ascii = 8'h6F;
      8'h4D: o_ascii = 8'h70;
      8'h15: o_ascii = 8'h71;
      8'h2D: o_ascii = 8'h72;
      8'h1B: o_ascii = 8'h73;
      8'h2C: o_ascii = 8'h74;
      8'h3C: o_ascii = 8'h75;
      8'h2A: o_ascii = 8'h76;
      8'h1D: o_ascii = 8'h77;
      8'h22: o_ascii = 8'h78;
      8'h35: o_ascii = 8'h79;
      8'h1A: o_ascii = 8'h7A;
      8'h45: o_ascii = 8'h30;
      8'h16: o_ascii = 8'h31;
      8'h1E: o_ascii = 8'h32;
      8'h26: o_ascii = 8'h33;
      8'h25: o_ascii = 8'h34;
      8'h2E: o_ascii = 8'h35;
      8'h36: o_ascii = 8'h36;
      8'h3D: o_ascii = 8'h37;
      8'h3E: o_ascii = 8'h38;
      8'h46: o_ascii = 8'h39;
      8'h29: o_ascii = 8'h20;
      8'h5A: o_ascii = 8'h0D;
      default: o_ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: drains the receiver FIFO, assembles key events and
// hands them out one at a time. Define PS2_TYPEMATIC_EN to report key repeats.
module ps2_kbd_ctrl #(
  parameter int CNT_W   = 16,
  parameter int E1_SKIP = 7
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             kbd_ready,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ack,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             evt_repeat,
  output logic [7:0]       evt_ascii,
  output logic [CNT_W-1:0] press_count,
  output logic             err_overflow
);

  import ps2_pkg::*;

  localparam int SKIP_W = (E1_SKIP < 2) ? 1 : $clog2(E1_SKIP + 1);

  ps2_state_e         r_state;
  logic [7:0]         r_byte;
  logic               r_nextdata_n;
  logic               r_ext_pend;
  logic               r_brk_pend;
  logic [SKIP_W-1:0]  r_skip;
  logic               r_held_vld;
  logic [7:0]         r_held_code;
  logic               r_held_ext;
  logic               r_evt_valid;
  logic [7:0]         r_evt_code;
  logic               r_evt_ext;
  logic               r_evt_break;
  logic [CNT_W-1:0]   r_press_count;
  logic               r_err_ovf;
  logic               w_held_match;
  logic [7:0]         w_rom_ascii;
`ifdef PS2_TYPEMATIC_EN
  logic               r_evt_repeat;
`endif

  assign w_held_match = r_held_vld && (r_held_code == r_byte) && (r_held_ext == r_ext_pend);

  // One byte per IDLE->POP->SETTLE->DECODE pass; EMIT blocks further pops until acked.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state       <= S_IDLE;
      r_byte        <= 8'h00;
      r_nextdata_n  <= 1'b1;
      r_ext_pend    <= 1'b0;
      r_brk_pend    <= 1'b0;
      r_skip        <= '0;
      r_held_vld    <= 1'b0;
      r_held_code   <= 8'h00;
      r_held_ext    <= 1'b0;
      r_evt_valid   <= 1'b0;
      r_evt_code    <= 8'h00;
      r_evt_ext     <= 1'b0;
      r_evt_break   <= 1'b0;
      r_press_count <= '0;
`ifdef PS2_TYPEMATIC_EN
      r_evt_repeat  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (kbd_ready) begin
            r_byte       <= kbd_data;
            r_nextdata_n <= 1'b0;
            r_state      <= S_POP;
          end
        end
        S_POP: begin
          r_nextdata_n <= 1'b1;
          r_state      <= S_SETTLE;
        end
        S_SETTLE: begin
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (r_skip != '0) begin
            r_skip  <= r_skip - SKIP_W'(1);
            r_state <= S_IDLE;
          end else if (r_byte == PS2_PAUSE) begin
            r_skip     <= SKIP_W'(E1_SKIP);
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
            r_state    <= S_IDLE;
          end else if (r_byte == PS2_EXT) begin
            r_ext_pend <= 1'b1;
            r_state    <= S_IDLE;
          end else if (r_byte == PS2_BRK) begin
            r_brk_pend <= 1'b1;
            r_state    <= S_IDLE;
          end else if (is_filter_code(r_byte) && !r_ext_pend && !r_brk_pend) begin
            r_state <= S_IDLE;
          end else begin
            r_ext_pend  <= 1'b0;
            r_brk_pend  <= 1'b0;
            r_evt_code  <= r_byte;
            r_evt_ext   <= r_ext_pend;
            r_evt_break <= r_brk_pend;
`ifdef PS2_TYPEMATIC_EN
            r_evt_repeat <= !r_brk_pend && w_held_match;
`endif
            if (r_brk_pend) begin
              if (w_held_match) r_held_vld <= 1'b0;
              r_evt_valid <= 1'b1;
              r_state     <= S_EMIT;
            end else if (w_held_match) begin
`ifdef PS2_TYPEMATIC_EN
              r_evt_valid <= 1'b1;
              r_state     <= S_EMIT;
`else
              r_state     <= S_IDLE;
`endif
            end else begin
              r_held_vld  <= 1'b1;
              r_held_code <= r_byte;
              r_held_ext  <= r_ext_pend;
              if (r_press_count != {CNT_W{1'b1}})
                r_press_count <= r_press_count + CNT_W'(1);
              r_evt_valid <= 1'b1;
              r_state     <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (evt_ack) begin
            r_evt_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_nextdata_n <= 1'b1;
          r_evt_valid  <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_err_ovf <= 1'b0;
    else       r_err_ovf <= r_err_ovf | kbd_overflow;
  end

  ps2_scan2ascii u_scan2ascii (
    .i_code  (r_evt_code),
    .o_ascii (w_rom_ascii)
  );

  assign kbd_nextdata_n = r_nextdata_n;
  assign evt_valid      = r_evt_valid;
  assign evt_code       = r_evt_code;
  assign evt_ext        = r_evt_ext;
  assign evt_break      = r_evt_break;
  assign evt_ascii      = (r_evt_ext || r_evt_break) ? 8'h00 : w_rom_ascii;
  assign press_count    = r_press_count;
  assign err_overflow   = r_err_ovf;
`ifdef PS2_TYPEMATIC_EN
  assign evt_repeat     = r_evt_repeat;
`else
  assign evt_repeat     = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: models the receiver FIFO and an event
// consumer, and checks events, pop pulses, counters and reset behaviour.
module tb_ps2_kbd_ctrl;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic [7:0] ascii;
  } evt_t;

  logic        clk = 1'b0;
  logic        clrn;
  logic        kbd_ready;
  logic [7:0]  kbd_data;
  logic        kbd_overflow;
  logic        kbd_nextdata_n;
  logic        evt_valid;
  logic        evt_ack;
  logic [7:0]  evt_code;
  logic        evt_ext;
  logic        evt_break;
  logic        evt_repeat;
  logic [7:0]  evt_ascii;
  logic [15:0] press_count;
  logic        err_overflow;

  int   vectors = 0;
  int   miscompares = 0;
  int   exp_count = 0;
  int   pop_count = 0;
  int   low_run = 0;
  int   max_low_run = 0;
  int   global_max_low = 0;
  bit   auto_ack = 1'b1;
  logic [7:0] fifo[$];
  evt_t evq[$];

  ps2_kbd_ctrl #(.CNT_W(16), .E1_SKIP(7)) dut (
    .clk            (clk),
    .clrn           (clrn),
    .kbd_ready      (kbd_ready),
    .kbd_data       (kbd_data),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .evt_valid      (evt_valid),
    .evt_ack        (evt_ack),
    .evt_code       (evt_code),
    .evt_ext        (evt_ext),
    .evt_break      (evt_break),
    .evt_repeat     (evt_repeat),
    .evt_ascii      (evt_ascii),
    .press_count    (press_count),
    .err_overflow   (err_overflow)
  );

  always #5 clk = ~clk;

  function automatic evt_t mk(input logic [7:0] c, input logic e, input logic b,
                              input logic r, input logic [7:0] a);
    return {c, e, b, r, a};
  endfunction

  // Advance to the next falling edge and play receiver FIFO and event consumer.
  task automatic tick();
    evt_t ev;
    @(negedge clk);
    if (kbd_nextdata_n === 1'b0) begin
      pop_count++;
      low_run++;
      if (low_run > max_low_run) max_low_run = low_run;
      if (low_run > global_max_low) global_max_low = low_run;
      if (fifo.size() != 0) void'(fifo.pop_front());
    end else begin
      low_run = 0;
    end
    if (evt_ack) begin
      evt_ack = 1'b0;
    end else if (auto_ack && evt_valid === 1'b1) begin
      ev = {evt_code, evt_ext, evt_break, evt_repeat, evt_ascii};
      evq.push_back(ev);
      evt_ack = 1'b1;
    end
    kbd_ready = (fifo.size() != 0);
    kbd_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo.push_back(b);
    kbd_ready = 1'b1;
    kbd_data  = fifo[0];
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (evt_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (evt_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s timeout: evt_valid=%b after %0d cycles, want 1", name, evt_valid, n);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({kbd_nextdata_n, evt_valid, evt_ext, evt_break, evt_repeat, err_overflow} !== 6'b100000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b, want 100000",
               {kbd_nextdata_n, evt_valid, evt_ext, evt_break, evt_repeat, err_overflow});
    end
    vectors++;
    if (evt_code !== 8'h00 || evt_ascii !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_code: got %h/%h, want 00/00", evt_code, evt_ascii);
    end
    vectors++;
    if (press_count !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_count: got %0d, want 0", press_count);
    end
    clrn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_make_break();
    logic [7:0] seq[] = '{8'h1C, 8'hF0, 8'h1C};
    evt_t want[$];
    evq.delete();
    pop_count = 0;
    max_low_run = 0;
    foreach (seq[i]) push_byte(seq[i]);
    repeat (40) tick();
    want.push_back(mk(8'h1C, 1'b0, 1'b0, 1'b0, 8'h61));
    want.push_back(mk(8'h1C, 1'b0, 1'b1, 1'b0, 8'h00));
    exp_count++;
    vectors++;
    if (evq.size() != want.size()) begin
      miscompares++;
      $display("[TB] FAIL make_break count: got %0d, want %0d", evq.size(), want.size());
    end
    for (int i = 0; i < want.size() && i < evq.size(); i++) begin
      vectors++;
      if (evq[i] !== want[i]) begin
        miscompares++;
        $display("[TB] FAIL make_break evt%0d: got %h, want %h", i, evq[i], want[i]);
      end
    end
    vectors++;
    if (press_count !== 16'(exp_count)) begin
      miscompares++;
      $display("[TB] FAIL make_break press_count: got %0d, want %0d", press_count, exp_count);
    end
    vectors++;
    if (pop_count != 3 || max_low_run != 1) begin
      miscompares++;
      $display("[TB] FAIL make_break pops: got %0d pulses width %0d, want 3 width 1", pop_count, max_low_run);
    end
  endtask

  task automatic test_extended();
    logic [7:0] seq[] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    evt_t want[$];
    evq.delete();
    foreach (seq[i]) push_byte(seq[i]);
    repeat (60) tick();
    want.push_back(mk(8'h75, 1'b1, 1'b0, 1'b0, 8'h00));
    want.push_back(mk(8'h75, 1'b1, 1'b1, 1'b0, 8'h00));
    exp_count++;
    vectors++;
    if (evq.size() != want.size()) begin
      miscompares++;
      $display("[TB] FAIL extended count: got %0d, want %0d", evq.size(), want.size());
    end
    for (int i = 0; i < want.size() && i < evq.size(); i++) begin
      vectors++;
      if (evq[i] !== want[i]) begin
        miscompares++;
        $display("[TB] FAIL extended evt%0d: got %h, want %h", i, evq[i], want[i]);
      end
    end
    vectors++;
    if (press_count !== 16'(exp_count)) begin
      miscompares++;
      $display("[TB] FAIL extended press_count: got %0d, want %0d", press_count, exp_count);
    end
  endtask

  task automatic test_typematic();
    logic [7:0] seq[] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    evt_t want[$];
    evq.delete();
    foreach (seq[i]) push_byte(seq[i]);
    repeat (60) tick();
    want.push_back(mk(8'h1C, 1'b0, 1'b0, 1'b0, 8'h61));
`ifdef PS2_TYPEMATIC_EN
    want.push_back(mk(8'h1C, 1'b0, 1'b0, 1'b1, 8'h61));
    want.push_back(mk(8'h1C, 1'b0, 1'b0, 1'b1, 8'h61));
`endif
    want.push_back(mk(8'h1C, 1'b0, 1'b1, 1'b0, 8'h00));
    exp_count++;
    vectors++;
    if (evq.size() != want.size()) begin
      miscompares++;
      $display("[TB] FAIL typematic count: got %0d, want %0d", evq.size(), want.size());
    end
    for (int i = 0; i < want.size() && i < evq.size(); i++) begin
      vectors++;
      if (evq[i] !== want[i]) begin
        miscompares++;
        $display("[TB] FAIL typematic evt%0d: got %h, want %h", i, evq[i], want[i]);
      end
    end
    vectors++;
    if (press_count !== 16'(exp_count)) begin
      miscompares++;
      $display("[TB] FAIL typematic press_count: got %0d, want %0d", press_count, exp_count);
    end
  endtask

  task automatic test_filter();
    logic [7:0] seq[] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'h29, 8'hF0, 8'h29};
    evt_t want[$];
    evq.delete();
    foreach (seq[i]) push_byte(seq[i]);
    repeat (90) tick();
    want.push_back(mk(8'h29, 1'b0, 1'b0, 1'b0, 8'h20));
    want.push_back(mk(8'h29, 1'b0, 1'b1, 1'b0, 8'h00));
    exp_count++;
    vectors++;
    if (evq.size() != want.size()) begin
      miscompares++;
      $display("[TB] FAIL filter count: got %0d, want %0d", evq.size(), want.size());
    end
    for (int i = 0; i < want.size() && i < evq.size(); i++) begin
      vectors++;
      if (evq[i] !== want[i]) begin
        miscompares++;
        $display("[TB] FAIL filter evt%0d: got %h, want %h", i, evq[i], want[i]);
      end
    end
    vectors++;
    if (press_count !== 16'(exp_count)) begin
      miscompares++;
      $display("[TB] FAIL filter press_count: got %0d, want %0d", press_count, exp_count);
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq[] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h32};
    evt_t want;
    evq.delete();
    foreach (seq[i]) push_byte(seq[i]);
    repeat (90) tick();
    want = mk(8'h32, 1'b0, 1'b0, 1'b0, 8'h62);
    exp_count++;
    vectors++;
    if (evq.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL pause count: got %0d, want 1", evq.size());
    end
    if (evq.size() >= 1) begin
      vectors++;
      if (evq[0] !== want) begin
        miscompares++;
        $display("[TB] FAIL pause evt0: got %h, want %h", evq[0], want);
      end
    end
    vectors++;
    if (press_count !== 16'(exp_count)) begin
      miscompares++;
      $display("[TB] FAIL pause press_count: got %0d, want %0d", press_count, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[] = '{8'h16, 8'h1E, 8'hF0, 8'h1E};
    evt_t want[$];
    evt_t snap, first;
    bit   stable = 1'b1;
    evq.delete();
    pop_count = 0;
    auto_ack = 1'b0;
    foreach (seq[i]) push_byte(seq[i]);
    wait_valid("backpressure");
    first = mk(8'h16, 1'b0, 1'b0, 1'b0, 8'h31);
    snap  = {evt_code, evt_ext, evt_break, evt_repeat, evt_ascii};
    vectors++;
    if (snap !== first) begin
      miscompares++;
      $display("[TB] FAIL backpressure first: got %h, want %h", snap, first);
    end
    repeat (50) begin
      tick();
      if (evt_valid !== 1'b1 || {evt_code, evt_ext, evt_break, evt_repeat, evt_ascii} !== first)
        stable = 1'b0;
    end
    vectors++;
    if (!stable) begin
      miscompares++;
      $display("[TB] FAIL backpressure hold: got unstable event, want %h held", first);
    end
    vectors++;
    if (pop_count != 1 || fifo.size() != 3) begin
      miscompares++;
      $display("[TB] FAIL backpressure pops: got %0d pops %0d queued, want 1 pops 3 queued",
               pop_count, fifo.size());
    end
    auto_ack = 1'b1;
    repeat (60) tick();
    want.push_back(first);
    want.push_back(mk(8'h1E, 1'b0, 1'b0, 1'b0, 8'h32));
    want.push_back(mk(8'h1E, 1'b0, 1'b1, 1'b0, 8'h00));
    exp_count += 2;
    vectors++;
    if (evq.size() != want.size()) begin
      miscompares++;
      $display("[TB] FAIL backpressure count: got %0d, want %0d", evq.size(), want.size());
    end
    for (int i = 0; i < want.size() && i < evq.size(); i++) begin
      vectors++;
      if (evq[i] !== want[i]) begin
        miscompares++;
        $display("[TB] FAIL backpressure evt%0d: got %h, want %h", i, evq[i], want[i]);
      end
    end
    vectors++;
    if (press_count !== 16'(exp_count)) begin
      miscompares++;
      $display("[TB] FAIL backpressure press_count: got %0d, want %0d", press_count, exp_count);
    end
  endtask

  task automatic test_reset_in_emit();
    evt_t want;
    evq.delete();
    auto_ack = 1'b0;
    push_byte(8'h45);
    wait_valid("reset_emit");
    clrn = 1'b0;
    kbd_overflow = 1'b1;
    #1;
    vectors++;
    if ({kbd_nextdata_n, evt_valid, evt_ext, evt_break, evt_repeat, err_overflow} !== 6'b100000) begin
      miscompares++;
      $display("[TB] FAIL reset_emit flags: got %b, want 100000",
               {kbd_nextdata_n, evt_valid, evt_ext, evt_break, evt_repeat, err_overflow});
    end
    vectors++;
    if (evt_code !== 8'h00 || press_count !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_emit state: got code %h count %0d, want 00 and 0", evt_code, press_count);
    end
    repeat (3) tick();
    vectors++;
    if (err_overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_emit ovf_in_reset: got %b, want 0", err_overflow);
    end
    kbd_overflow = 1'b0;
    tick();
    clrn = 1'b1;
    repeat (2) tick();
    vectors++;
    if (err_overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL overflow_idle: got %b, want 0", err_overflow);
    end
    kbd_overflow = 1'b1;
    tick();
    kbd_overflow = 1'b0;
    repeat (5) tick();
    vectors++;
    if (err_overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overflow_sticky: got %b, want 1", err_overflow);
    end
    auto_ack = 1'b1;
    evq.delete();
    push_byte(8'h45);
    repeat (30) tick();
    want = mk(8'h45, 1'b0, 1'b0, 1'b0, 8'h30);
    vectors++;
    if (evq.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL post_reset count: got %0d, want 1", evq.size());
    end
    if (evq.size() >= 1) begin
      vectors++;
      if (evq[0] !== want) begin
        miscompares++;
        $display("[TB] FAIL post_reset evt0: got %h, want %h", evq[0], want);
      end
    end
    vectors++;
    if (press_count !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL post_reset press_count: got %0d, want 1", press_count);
    end
  endtask

  initial begin
    clrn = 1'b0;
    kbd_ready = 1'b0;
    kbd_data = 8'h00;
    kbd_overflow = 1'b0;
    evt_ack = 1'b0;
    test_reset();
    test_make_break();
    test_extended();
    test_typematic();
    test_filter();
    test_pause();
    test_back_to_back();
    test_reset_in_emit();
    vectors++;
    if (global_max_low != 1) begin
      miscompares++;
      $display("[TB] FAIL pop_width: got %0d cycles, want 1", global_max_low);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
